// File: rtl/fetch_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fetch_sequencer_pkg
// Purpose : Shared types and constants for the instruction fetch sequencer:
//           FSM state encoding, PC reset value/step, buffer depth, the
//           buffer entry layout and a PC alignment helper.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package fetch_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  localparam logic [15:0] RESET_PC    = 16'h0000;
  localparam logic [15:0] PC_STEP     = 16'd2;
  localparam int          FETCH_DEPTH = 2;

  // One buffered fetch: byte address in the upper half, instruction below.
  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] instr;
  } fetch_entry_t;

  // Instructions are halfword aligned; bit 0 of any target is dropped.
  function automatic logic [15:0] align_pc(input logic [15:0] addr);
    return {addr[15:1], 1'b0};
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_sequencer_fifo.sv
`default_nettype none
// ============================================================================
// Module  : fetch_fifo
// Purpose : Small FIFO holding fetched {pc, instr} entries between the fetch
//           stage and decode. Supports push and pop on the same edge even when
//           full, plus a synchronous clear used for flushes.
// Ports   : clock, reset       - clock / asynchronous active-high reset
//           clear              - discard all entries at the edge
//           push, push_data    - write an entry (accepted if room or pop)
//           pop                - remove the head entry (ignored when empty)
//           head_data          - head entry, zero when empty
//           full, empty        - occupancy flags
// Revision: 1.0 - initial release
// ============================================================================
module fetch_fifo
  import fetch_sequencer_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output fetch_entry_t head_data,
  output logic         full,
  output logic         empty
);

  localparam int              PTR_W      = $clog2(FETCH_DEPTH);
  localparam logic [PTR_W:0]  FULL_COUNT = FETCH_DEPTH[PTR_W:0];

  fetch_entry_t       r_mem [FETCH_DEPTH];
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W:0]     r_count;

  logic w_do_pop;
  logic w_do_push;

  assign empty     = (r_count == '0);
  assign full      = (r_count == FULL_COUNT);
  assign w_do_pop  = pop & ~empty;
  // When full, the slot being written is the head that leaves this edge,
  // so a simultaneous push/pop keeps occupancy and ordering intact.
  assign w_do_push = push & (~full | w_do_pop);
  assign head_data = empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < FETCH_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (clear) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= push_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : fetch_sequencer
// Purpose : Sequential instruction fetch unit. Walks a 16-bit byte-addressed
//           PC in steps of 2, reads instruction memory combinationally and
//           buffers fetched words in a 2-entry FIFO for decode. Supports
//           start, halt (highest priority) and redirect (flush + refetch).
// Ports   : clock, reset           - clock / asynchronous active-high reset
//           start                  - begin fetching from PC (IDLE only)
//           halt                   - flush and return to IDLE, PC held
//           redirect, redirect_pc  - flush and refetch from new target
//           iaddr, idata           - instruction memory address / data
//           inst, inst_pc          - head instruction and its address
//           inst_valid, inst_ready - decode handshake
//           busy                   - high when not IDLE
// Revision: 1.0 - initial release
// ============================================================================
module fetch_sequencer
  import fetch_sequencer_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        halt,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic [15:0] iaddr,
  input  logic [15:0] idata,
  output logic [15:0] inst,
  output logic [15:0] inst_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic        busy
);

  state_t       r_state;
  state_t       w_state_next;
  logic [15:0]  r_pc;
  logic [15:0]  w_pc_next;

  logic         w_push;
  logic         w_clear;
  logic         w_pop;
  logic         w_full;
  logic         w_empty;
  fetch_entry_t w_head;
  fetch_entry_t w_push_data;

  assign w_pop       = inst_valid & inst_ready;
  assign w_push_data = '{pc: r_pc, instr: idata};

  // State and PC registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
    end
  end

  // Next-state logic. halt beats redirect, which beats everything else.
  always_comb begin
    w_state_next = r_state;
    if (halt) begin
      w_state_next = ST_IDLE;
    end else if (redirect) begin
      w_state_next = ST_FETCH;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) w_state_next = ST_FETCH;
        end
        ST_FETCH: begin
          // Holding one entry, writing another and not popping fills it.
          if (w_push && !w_pop && !w_empty && !w_full) w_state_next = ST_FULL;
        end
        ST_FULL: begin
          if (w_pop) w_state_next = ST_FETCH;
        end
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  // Output / datapath control. FULL never writes, even with a pop; the
  // refill is issued from FETCH on the following edge.
  always_comb begin
    w_push    = 1'b0;
    w_clear   = 1'b0;
    w_pc_next = r_pc;
    if (halt) begin
      w_clear = 1'b1;
    end else if (redirect) begin
      w_clear   = 1'b1;
      w_pc_next = align_pc(redirect_pc);
    end else if (r_state == ST_FETCH && (!w_full || w_pop)) begin
      w_push    = 1'b1;
      w_pc_next = r_pc + PC_STEP;
    end
  end

  fetch_fifo u_fifo (
    .clock     (clock),
    .reset     (reset),
    .clear     (w_clear),
    .push      (w_push),
    .push_data (w_push_data),
    .pop       (w_pop),
    .head_data (w_head),
    .full      (w_full),
    .empty     (w_empty)
  );

  assign iaddr      = r_pc;
  assign inst_valid = ~w_empty;
  assign inst       = w_head.instr;
  assign inst_pc    = w_head.pc;
  assign busy       = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_fetch_sequencer
// Purpose : Self-checking bench for fetch_sequencer. Instruction memory is
//           modelled as idata = iaddr ^ 16'hA5A5. Expected fetch addresses
//           are queued as each scenario is driven and checked against every
//           instruction decode accepts.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;

  logic        clock;
  logic        reset;
  logic        start;
  logic        halt;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] iaddr;
  logic [15:0] idata;
  logic [15:0] inst;
  logic [15:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic        busy;

  int tests = 0;
  int fails = 0;
  logic [15:0] sb[$];

  fetch_sequencer dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .halt        (halt),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .iaddr       (iaddr),
    .idata       (idata),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .busy        (busy)
  );

  assign idata = iaddr ^ 16'hA5A5;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Sample at the falling edge (inputs already stable for the coming rising
  // edge), then advance to 1 time unit past the rising edge.
  task automatic tick();
    logic [15:0] exp_pc;
    @(negedge clock);
    if (!inst_valid) begin
      chk("idle_inst_zero", {16'h0, inst}, 32'h0);
      chk("idle_pc_zero", {16'h0, inst_pc}, 32'h0);
    end
    if (inst_valid && inst_ready) begin
      tests++;
      assert (sb.size() > 0)
      else begin
        fails++;
        $error("FAIL sb_underflow observed=pop_of_%h expected=no_pop", inst_pc);
      end
      if (sb.size() > 0) begin
        exp_pc = sb.pop_front();
        chk("inst_pc", {16'h0, inst_pc}, {16'h0, exp_pc});
        chk("inst", {16'h0, inst}, {16'h0, exp_pc ^ 16'hA5A5});
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #1;
    chk("rst_valid", {31'h0, inst_valid}, 32'h0);
    chk("rst_inst", {16'h0, inst}, 32'h0);
    chk("rst_inst_pc", {16'h0, inst_pc}, 32'h0);
    chk("rst_iaddr", {16'h0, iaddr}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    #2;
    reset = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    start       = 1'b0;
    halt        = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 16'h0;
    inst_ready  = 1'b0;
    #2;
    chk("por_busy", {31'h0, busy}, 32'h0);
    chk("por_iaddr", {16'h0, iaddr}, 32'h0);
    chk("por_valid", {31'h0, inst_valid}, 32'h0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Streaming with decode always ready.
    inst_ready = 1'b1;
    start      = 1'b1;
    tick();
    start = 1'b0;
    chk("s1_busy", {31'h0, busy}, 32'h1);
    chk("s1_iaddr0", {16'h0, iaddr}, 32'h0);
    chk("s1_valid_early", {31'h0, inst_valid}, 32'h0);
    sb.push_back(16'h0000); sb.push_back(16'h0002);
    sb.push_back(16'h0004); sb.push_back(16'h0006);
    tick();
    chk("s1_valid", {31'h0, inst_valid}, 32'h1);
    repeat (4) tick();
    chk("s1_drain", sb.size(), 32'h0);
    inst_ready = 1'b0;
    halt       = 1'b1;
    tick();
    halt = 1'b0;
    chk("s1_halt_busy", {31'h0, busy}, 32'h0);
    chk("s1_halt_valid", {31'h0, inst_valid}, 32'h0);
    chk("s1_halt_pc", {16'h0, iaddr}, 32'h000A);

    // Backpressure fills the buffer, then release.
    pulse_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    chk("s2_full_pc", {16'h0, iaddr}, 32'h0004);
    chk("s2_full_head", {16'h0, inst_pc}, 32'h0000);
    chk("s2_full_busy", {31'h0, busy}, 32'h1);
    sb.push_back(16'h0000); sb.push_back(16'h0002); sb.push_back(16'h0004);
    inst_ready = 1'b1;
    repeat (3) tick();
    chk("s2_drain", sb.size(), 32'h0);

    // Redirect with a full buffer while decode accepts the head.
    inst_ready = 1'b0;
    tick();
    chk("s3_pre_pc", {16'h0, iaddr}, 32'h000A);
    chk("s3_pre_head", {16'h0, inst_pc}, 32'h0006);
    inst_ready  = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 16'h0031;
    sb.push_back(16'h0006);
    tick();
    redirect = 1'b0;
    chk("s3_flushed", {31'h0, inst_valid}, 32'h0);
    chk("s3_target", {16'h0, iaddr}, 32'h0030);
    sb.push_back(16'h0030); sb.push_back(16'h0032);
    repeat (3) tick();
    chk("s3_drain", sb.size(), 32'h0);

    // halt and redirect together: halt wins, PC held.
    inst_ready  = 1'b0;
    halt        = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 16'h0100;
    tick();
    halt     = 1'b0;
    redirect = 1'b0;
    chk("s4_busy", {31'h0, busy}, 32'h0);
    chk("s4_valid", {31'h0, inst_valid}, 32'h0);
    chk("s4_pc", {16'h0, iaddr}, 32'h0036);
    repeat (2) tick();
    chk("s4_pc_hold", {16'h0, iaddr}, 32'h0036);
    chk("s4_idle_valid", {31'h0, inst_valid}, 32'h0);
    inst_ready = 1'b1;
    start      = 1'b1;
    tick();
    start = 1'b0;
    sb.push_back(16'h0036); sb.push_back(16'h0038);
    repeat (3) tick();
    chk("s4_drain", sb.size(), 32'h0);

    // start while busy is ignored (no effect on PC sequence); wrap-around.
    inst_ready  = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 16'hFFFC;
    start       = 1'b1;
    tick();
    redirect   = 1'b0;
    start      = 1'b0;
    inst_ready = 1'b1;
    chk("s5_target", {16'h0, iaddr}, 32'hFFFC);
    sb.push_back(16'hFFFC); sb.push_back(16'hFFFE);
    sb.push_back(16'h0000); sb.push_back(16'h0002);
    repeat (5) tick();
    chk("s5_drain", sb.size(), 32'h0);
    chk("s5_valid", {31'h0, inst_valid}, 32'h1);

    // Asynchronous reset mid-fetch discards everything.
    pulse_reset();
    tick();
    chk("s6_idle_busy", {31'h0, busy}, 32'h0);
    chk("s6_idle_valid", {31'h0, inst_valid}, 32'h0);
    start = 1'b1;
    tick();
    start = 1'b0;
    sb.push_back(16'h0000);
    repeat (2) tick();
    inst_ready = 1'b0;
    tick();
    chk("s6_drain", sb.size(), 32'h0);
    chk("s6_pc", {16'h0, iaddr}, 32'h0006);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
